// File: rtl/cfg_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : cfg_loader_if
//  Description : Byte-stream handshake bundle feeding the configuration
//                loader: data byte, valid/ready pair and frame resync.
//                master = stream source, slave = cfg_loader.
//  Signals     : cfg_byte  [7:0] stream byte        (master -> slave)
//                cfg_valid       cfg_byte valid      (master -> slave)
//                cfg_sync        frame resync        (master -> slave)
//                cfg_ready       loader can accept   (slave  -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface cfg_loader_if;
    logic [7:0] cfg_byte;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       cfg_sync;

    modport master (
        output cfg_byte,
        output cfg_valid,
        output cfg_sync,
        input  cfg_ready
    );

    modport slave (
        input  cfg_byte,
        input  cfg_valid,
        input  cfg_sync,
        output cfg_ready
    );
endinterface
`default_nettype wire

// File: rtl/cfg_loader.sv
`default_nettype none
// ============================================================================
//  Module      : cfg_loader
//  Description : Configuration front end for the LUT-block array. Parses
//                5-byte frames (address, x, y, ab, cx) from a valid/ready
//                byte stream and drives the shared cfg_out bus plus one-hot
//                per-block set strobes, one cycle after each data byte.
//  Macro       : CFG_LOADER_BCAST_EN - address 8'hFF broadcasts to all blocks
//                (undefined: 8'hFF is an ordinary out-of-range address).
//  Ports       : clk, rst_n (async assert, active low)
//                cfg        cfg_loader_if.slave (byte/valid/ready/sync)
//                cfg_out    [7:0]  registered shared config data
//                set_x/y/ab/cx [NUM_BLOCKS-1:0] one-hot load strobes
//                frame_done pulse with the final set_cx strobe
//                err        sticky out-of-range address flag
//                frame_cnt  [7:0]  completed frame count (wrapping)
//  Revision    : 1.0  initial release
// ============================================================================
module cfg_loader #(
    parameter int NUM_BLOCKS = 16,
    parameter int ADDR_W     = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    cfg_loader_if.slave                cfg,
    output logic [7:0]                 cfg_out,
    output logic [NUM_BLOCKS-1:0]      set_x,
    output logic [NUM_BLOCKS-1:0]      set_y,
    output logic [NUM_BLOCKS-1:0]      set_ab,
    output logic [NUM_BLOCKS-1:0]      set_cx,
    output logic                       frame_done,
    output logic                       err,
    output logic [7:0]                 frame_cnt
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_DATA = 2'd1;
    localparam logic [1:0] c_SKIP = 2'd2;

    localparam logic [7:0]            c_ADDR_LIMIT = 8'(NUM_BLOCKS);
    localparam logic [7:0]            c_BCAST_ADDR = 8'hFF;
    localparam logic [NUM_BLOCKS-1:0] c_ONE        = {{(NUM_BLOCKS-1){1'b0}}, 1'b1};

    logic [1:0]            r_state;
    logic [1:0]            r_idx;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_bcast;
    logic [7:0]            r_cfg_out;
    logic [NUM_BLOCKS-1:0] r_set_x;
    logic [NUM_BLOCKS-1:0] r_set_y;
    logic [NUM_BLOCKS-1:0] r_set_ab;
    logic [NUM_BLOCKS-1:0] r_set_cx;
    logic                  r_frame_done;
    logic                  r_err;
    logic [7:0]            r_frame_cnt;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_bcast_hit;
    logic                  w_addr_ok;
    logic [NUM_BLOCKS-1:0] w_mask;

    // Ready is never withheld for flow control; only resync (and reset)
    // refuse a byte.
    assign w_ready       = rst_n & ~cfg.cfg_sync;
    assign cfg.cfg_ready = w_ready;
    assign w_accept      = cfg.cfg_valid & w_ready;

`ifdef CFG_LOADER_BCAST_EN
    assign w_bcast_hit = (cfg.cfg_byte == c_BCAST_ADDR);
`else
    assign w_bcast_hit = 1'b0;
`endif

    assign w_addr_ok = (cfg.cfg_byte < c_ADDR_LIMIT) | w_bcast_hit;

    // Target vector for the current frame: single block or all blocks.
    assign w_mask = r_bcast ? {NUM_BLOCKS{1'b1}} : (c_ONE << r_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_idx        <= 2'd0;
            r_addr       <= '0;
            r_bcast      <= 1'b0;
            r_cfg_out    <= 8'd0;
            r_set_x      <= '0;
            r_set_y      <= '0;
            r_set_ab     <= '0;
            r_set_cx     <= '0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
            r_frame_cnt  <= 8'd0;
        end else begin
            // Strobes live for exactly one cycle after an accepted data byte.
            r_set_x      <= '0;
            r_set_y      <= '0;
            r_set_ab     <= '0;
            r_set_cx     <= '0;
            r_frame_done <= 1'b0;

            if (cfg.cfg_sync) begin
                r_state <= c_IDLE;
                r_idx   <= 2'd0;
                r_err   <= 1'b0;
            end else if (w_accept) begin
                case (r_state)
                    c_IDLE: begin
                        r_idx <= 2'd0;
                        if (w_addr_ok) begin
                            r_addr  <= ADDR_W'(cfg.cfg_byte);
                            r_bcast <= w_bcast_hit;
                            r_state <= c_DATA;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= c_SKIP;
                        end
                    end
                    c_DATA: begin
                        r_cfg_out <= cfg.cfg_byte;
                        r_idx     <= r_idx + 2'd1;
                        case (r_idx)
                            2'd0: r_set_x  <= w_mask;
                            2'd1: r_set_y  <= w_mask;
                            2'd2: r_set_ab <= w_mask;
                            default: begin
                                r_set_cx     <= w_mask;
                                r_frame_done <= 1'b1;
                                r_frame_cnt  <= r_frame_cnt + 8'd1;
                                r_state      <= c_IDLE;
                            end
                        endcase
                    end
                    c_SKIP: begin
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_state <= c_IDLE;
                        end
                    end
                    default: begin
                        r_state <= c_IDLE;
                        r_idx   <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign cfg_out    = r_cfg_out;
    assign set_x      = r_set_x;
    assign set_y      = r_set_y;
    assign set_ab     = r_set_ab;
    assign set_cx     = r_set_cx;
    assign frame_done = r_frame_done;
    assign err        = r_err;
    assign frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire
